sram_bus_arbiter: RTL

Parametrised successor to the single-master RAM adapter. It arbitrates the CPU instruction-fetch master and data master onto NUM_BANKS word-wide asynchronous SRAM banks. Accesses use byte-lane enables and a configurable number of wait states. It sits between samming_cpu and the SRAM pins in the SOPC top; the top converts the split dq_o/dq_i/dq_oe signals to inout pins.

---
 rtl/sram_bus_arbiter_if.sv | 47 ++++
 rtl/sram_bus_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter_if.sv
// CPU-side (fetch + data masters) and SRAM-side signal bundle for sram_bus_arbiter.
// The slave modport is the arbiter; the master modport is the CPU/SRAM environment around it.
interface sram_bus_arbiter_if #(
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned NUM_BANKS = 2
);
  logic                          inst_req;
  logic [31:0]                   inst_addr;
  logic [31:0]                   inst_rdata;
  logic                          inst_ready;

  logic                          data_req;
  logic                          data_we;
  logic [3:0]                    data_sel;
  logic [31:0]                   data_addr;
  logic [31:0]                   data_wdata;
  logic [31:0]                   data_rdata;
  logic                          data_ready;
  logic                          data_err;

  logic [NUM_BANKS*ADDR_W-1:0]   sram_addr;
  logic [NUM_BANKS*32-1:0]       sram_dq_o;
  logic [NUM_BANKS*32-1:0]       sram_dq_i;
  logic [NUM_BANKS-1:0]          sram_dq_oe;
  logic [NUM_BANKS-1:0]          sram_ce_n;
  logic [NUM_BANKS-1:0]          sram_oe_n;
  logic [NUM_BANKS-1:0]          sram_we_n;
  logic [NUM_BANKS*4-1:0]        sram_be_n;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_we, data_sel, data_addr, data_wdata,
    input  sram_dq_i,
    output inst_rdata, inst_ready,
    output data_rdata, data_ready, data_err,
    output sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_we, data_sel, data_addr, data_wdata,
    output sram_dq_i,
    input  inst_rdata, inst_ready,
    input  data_rdata, data_ready, data_err,
    input  sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-master (fetch/data) arbiter onto NUM_BANKS asynchronous SRAM banks with
// byte enables and WAIT_CYCLES extra access cycles; alternating priority on ties.
module sram_bus_arbiter #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned BANK_SEL_W  = 1,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  sram_bus_arbiter_if.slave  bus
);

  localparam int unsigned BANK_LO = ADDR_W + 2;
  localparam int unsigned BANK_HI = ADDR_W + BANK_SEL_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RELEASE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_wait;
  logic                  r_grant_data;
  logic                  r_last_data;
  logic                  r_we;
  logic                  r_oor;
  logic [3:0]            r_sel;
  logic [ADDR_W-1:0]     r_word;
  logic [BANK_SEL_W-1:0] r_bank;
  logic [31:0]           r_wdata;
  logic [31:0]           r_inst_rdata;
  logic [31:0]           r_data_rdata;

  logic                  w_any_req;
  logic                  w_pick_data;
  logic [31:0]           w_addr;
  logic [BANK_SEL_W-1:0] w_bank;
  logic                  w_oor;
  logic                  w_active;
  logic [31:0]           w_rd;
  logic [NUM_BANKS-1:0]   w_ce_n;
  logic [NUM_BANKS-1:0]   w_oe_n;
  logic [NUM_BANKS-1:0]   w_we_n;
  logic [NUM_BANKS-1:0]   w_dq_oe;
  logic [NUM_BANKS*4-1:0] w_be_n;
  logic [2*(33-BANK_HI)-1:0] w_unused_addr;

  // Data wins unless the fetch master is also waiting and data was served last.
  assign w_any_req   = bus.inst_req | bus.data_req;
  assign w_pick_data = bus.data_req & (~bus.inst_req | ~r_last_data);
  assign w_addr      = w_pick_data ? bus.data_addr : bus.inst_addr;
  assign w_bank      = w_addr[BANK_HI:BANK_LO];
  assign w_oor       = ({1'b0, w_bank} >= (BANK_SEL_W + 1)'(NUM_BANKS));

  assign w_unused_addr = {bus.inst_addr[31:BANK_HI+1], bus.inst_addr[1:0],
                          bus.data_addr[31:BANK_HI+1], bus.data_addr[1:0]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_any_req) w_next = w_oor ? S_RELEASE : S_ACCESS;
      S_ACCESS:  if (r_wait == '0) w_next = S_RELEASE;
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_rd = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (r_bank == BANK_SEL_W'(b)) w_rd = bus.sram_dq_i[b*32 +: 32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait       <= '0;
      r_grant_data <= 1'b0;
      r_last_data  <= 1'b0;
      r_we         <= 1'b0;
      r_oor        <= 1'b0;
      r_sel        <= '0;
      r_word       <= '0;
      r_bank       <= '0;
      r_wdata      <= '0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant_data <= w_pick_data;
            r_we         <= w_pick_data & bus.data_we;
            r_sel        <= w_pick_data ? bus.data_sel : 4'hF;
            r_word       <= w_addr[ADDR_W+1:2];
            r_bank       <= w_bank;
            r_oor        <= w_oor;
            r_wait       <= 4'(WAIT_CYCLES);
            if (w_pick_data) r_wdata <= bus.data_wdata;
            if (w_oor) begin
              if (w_pick_data) r_data_rdata <= '0;
              else             r_inst_rdata <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - 4'd1;
          end else if (!r_we) begin
            if (r_grant_data) r_data_rdata <= w_rd;
            else              r_inst_rdata <= w_rd;
          end
        end
        S_RELEASE: r_last_data <= r_grant_data;
        default: ;
      endcase
    end
  end

  // Writes keep ce_n/dq_oe through RELEASE for data hold; reads release everything.
  assign w_active = (r_state == S_ACCESS) || ((r_state == S_RELEASE) && r_we && !r_oor);

  always_comb begin
    w_ce_n  = '1;
    w_oe_n  = '1;
    w_we_n  = '1;
    w_be_n  = '1;
    w_dq_oe = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (w_active && (r_bank == BANK_SEL_W'(b))) begin
        w_ce_n[b] = 1'b0;
        if (r_we) begin
          w_dq_oe[b]       = 1'b1;
          w_be_n[b*4 +: 4] = ~r_sel;
          w_we_n[b]        = !((r_state == S_ACCESS) && (r_sel != 4'b0000));
        end else begin
          w_oe_n[b]        = 1'b0;
          w_be_n[b*4 +: 4] = 4'b0000;
        end
      end
    end
  end

  assign bus.sram_addr  = {NUM_BANKS{r_word}};
  assign bus.sram_dq_o  = {NUM_BANKS{r_wdata}};
  assign bus.sram_ce_n  = w_ce_n;
  assign bus.sram_oe_n  = w_oe_n;
  assign bus.sram_we_n  = w_we_n;
  assign bus.sram_be_n  = w_be_n;
  assign bus.sram_dq_oe = w_dq_oe;

  assign bus.inst_ready = (r_state == S_RELEASE) && !r_grant_data;
  assign bus.data_ready = (r_state == S_RELEASE) && r_grant_data;
  assign bus.data_err   = (r_state == S_RELEASE) && r_grant_data && r_oor;
  assign bus.inst_rdata = r_inst_rdata;
  assign bus.data_rdata = r_data_rdata;

endmodule
